// File: rtl/hs32_irqlatch_if.sv
// MMIO strobe bus shared with hs32_aic16: one-cycle strobe, combinational ack/read data.
interface hs32_irqlatch_if;
    logic        stb;
    logic        ack;
    logic [2:0]  addr;
    logic [31:0] dtw;
    logic [31:0] dtr;
    logic        rw;

    modport master (output stb, addr, dtw, rw, input ack, dtr);
    modport slave  (input stb, addr, dtw, rw, output ack, dtr);
endinterface

// File: rtl/hs32_irqlatch.sv
// Interrupt front-end for hs32_aic16: synchronises raw IRQ lines, latches each
// as rising-edge or level, masks them and drives the AIC 'interrupts' bus.
module hs32_irqlatch #(
    parameter int NLINES      = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    hs32_irqlatch_if.slave    bus,
    input  logic [NLINES-1:0] irq_in,
    output logic [NLINES-1:0] interrupts
);

    typedef enum logic [2:0] {
        REG_PEND   = 3'd0,
        REG_MASK   = 3'd1,
        REG_EDGE   = 3'd2,
        REG_RAW    = 3'd3,
        REG_SWTRIG = 3'd4
    } reg_e;

    // Lines 0 and 1 are NMIs and can never be masked off.
    localparam logic [NLINES-1:0] NMI_BITS = NLINES'(3);

    logic [NLINES-1:0] sync_q [SYNC_STAGES];
    logic [NLINES-1:0] prev_q;
    logic [NLINES-1:0] pend_q, pend_d;
    logic [NLINES-1:0] mask_q, mask_d;
    logic [NLINES-1:0] edge_q, edge_d;
    logic [NLINES-1:0] s, rise;
    logic [NLINES-1:0] wdata, w1c_wr, swtrig_wr, rdata;
    logic              unused_wdata;

    assign s     = sync_q[SYNC_STAGES-1];
    assign rise  = s & ~prev_q;
    assign wdata = bus.dtw[NLINES-1:0];
    // Bits above NLINES are ignored on write.
    assign unused_wdata = ^bus.dtw;

    // Synchroniser chain bringing the asynchronous irq_in lines into clk.
    // NOTE: the chain is a small flop array, not a RAM, so it is reset like any
    // other register; that guarantees prev/s start at 0 and an edge line
    // already high latches exactly once after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else begin
            sync_q[0] <= irq_in;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    // Register write decode and pending next-state; set beats clear in edge mode.
    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        w1c_wr    = '0;
        swtrig_wr = '0;
        mask_d    = mask_q;
        edge_d    = edge_q;
        if (bus.stb && bus.rw) begin
            case (bus.addr)
                REG_PEND:   w1c_wr    = wdata;
                REG_MASK:   mask_d    = wdata | NMI_BITS;
                REG_EDGE:   edge_d    = wdata;
                REG_SWTRIG: swtrig_wr = wdata;
                default:    ;
            endcase
        end
        pend_d = (~edge_q & s) | (edge_q & (rise | swtrig_wr | (pend_q & ~w1c_wr)));
    end

    // Edge-detect history plus the software-visible state registers.
    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_q <= '0;
            pend_q <= '0;
            mask_q <= NMI_BITS;
            edge_q <= '0;
        end else begin
            prev_q <= s;
            pend_q <= pend_d;
            mask_q <= mask_d;
            edge_q <= edge_d;
        end
    end

    // Combinational read mux; write-only and reserved registers read as zero.
    always_comb begin
        rdata = '0;
        case (bus.addr)
            REG_PEND: rdata = pend_q;
            REG_MASK: rdata = mask_q;
            REG_EDGE: rdata = edge_q;
            REG_RAW:  rdata = s;
            default:  ;
        endcase
    end

    assign bus.dtr    = 32'(rdata);
    assign bus.ack    = bus.stb;
    assign interrupts = pend_q & mask_q;

endmodule

// File: tb/tb_hs32_irqlatch.sv
// Self-checking bench for hs32_irqlatch: directed scenarios followed by random
// traffic, all compared against a cycle-level reference model built from an
// input-history queue.
module tb_hs32_irqlatch;

    localparam int NL   = 24;
    localparam int SYNC = 2;
    localparam logic [2:0] A_PEND = 3'd0, A_MASK = 3'd1, A_EDGE = 3'd2,
                           A_RAW  = 3'd3, A_SWTRIG = 3'd4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NL-1:0] irq_in;
    logic [NL-1:0] interrupts;

    hs32_irqlatch_if bus ();

    hs32_irqlatch #(.NLINES(NL), .SYNC_STAGES(SYNC)) dut (
        .clk        (clk),
        .reset      (rst_n),
        .bus        (bus),
        .irq_in     (irq_in),
        .interrupts (interrupts)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [NL-1:0] hist[$];   // irq_in sampled at each edge since reset, newest first
    logic [NL-1:0] m_prev, m_pend, m_mask, m_edge;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [NL-1:0] m_s();
        return (hist.size() >= SYNC) ? hist[SYNC-1] : '0;
    endfunction

    task automatic m_reset();
        hist.delete();
        m_prev = '0;
        m_pend = '0;
        m_mask = NL'(3);
        m_edge = '0;
    endtask

    function automatic logic [31:0] m_read(input logic [2:0] a);
        case (a)
            A_PEND:  return 32'(m_pend);
            A_MASK:  return 32'(m_mask);
            A_EDGE:  return 32'(m_edge);
            A_RAW:   return 32'(m_s());
            default: return 32'h0;
        endcase
    endfunction

    // Advance one clock edge, update the model from the pre-edge inputs and
    // compare the interrupt bus.
    task automatic tick();
        logic [NL-1:0] smp, s_old, np, w1c, sw;
        logic          wr;
        logic [2:0]    a;
        logic [31:0]   d;
        smp = irq_in;
        wr  = bus.stb && bus.rw;
        a   = bus.addr;
        d   = bus.dtw;
        @(posedge clk);
        if (rst_n) begin
            s_old = m_s();
            w1c   = (wr && a == A_PEND)   ? d[NL-1:0] : '0;
            sw    = (wr && a == A_SWTRIG) ? d[NL-1:0] : '0;
            for (int i = 0; i < NL; i++) begin
                if (m_edge[i])
                    np[i] = (s_old[i] && !m_prev[i]) || sw[i] || (m_pend[i] && !w1c[i]);
                else
                    np[i] = s_old[i];
            end
            if (wr && a == A_MASK) m_mask = d[NL-1:0] | NL'(3);
            if (wr && a == A_EDGE) m_edge = d[NL-1:0];
            m_pend = np;
            m_prev = s_old;
            hist.push_front(smp);
            if (hist.size() > SYNC + 1) void'(hist.pop_back());
        end
        #1;
        check("irq_bus", 32'(interrupts), 32'(m_pend & m_mask));
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        bus.stb  = 1'b1;
        bus.rw   = 1'b1;
        bus.addr = a;
        bus.dtw  = d;
        tick();
        bus.stb  = 1'b0;
        bus.rw   = 1'b0;
    endtask

    task automatic bus_read_check(input string tag, input logic [2:0] a);
        bus.stb  = 1'b1;
        bus.rw   = 1'b0;
        bus.addr = a;
        #1;
        check(tag, bus.dtr, m_read(a));
        check("ack", 32'(bus.ack), 32'd1);
        bus.stb  = 1'b0;
    endtask

    task automatic const_read(input string tag, input logic [2:0] a, input logic [31:0] exp);
        bus.stb  = 1'b1;
        bus.rw   = 1'b0;
        bus.addr = a;
        #1;
        check(tag, bus.dtr, exp);
        bus.stb  = 1'b0;
    endtask

    initial begin
        bus.stb  = 1'b0;
        bus.rw   = 1'b0;
        bus.addr = '0;
        bus.dtw  = '0;
        irq_in   = '1;
        rst_n    = 1'b0;
        m_reset();
        #2;

        // 1. Reset with all lines high
        repeat (3) tick();
        check("rst_irq", 32'(interrupts), 32'h0);
        const_read("rst_mask", A_MASK, 32'h3);
        const_read("rst_pend", A_PEND, 32'h0);
        const_read("rst_edge", A_EDGE, 32'h0);
        rst_n = 1'b1;
        repeat (3) tick();
        check("nmi_level_after_rst", 32'(interrupts), 32'h3);
        irq_in = '0;
        repeat (4) tick();

        // 2. Level line 5 latency
        bus_write(A_MASK, 32'h20);
        const_read("mask_rd", A_MASK, 32'h23);
        irq_in[5] = 1'b1;
        tick(); check("lvl_rise_e1", 32'(interrupts[5]), 32'd0);
        tick(); check("lvl_rise_e2", 32'(interrupts[5]), 32'd0);
        tick(); check("lvl_rise_e3", 32'(interrupts[5]), 32'd1);
        irq_in[5] = 1'b0;
        tick(); check("lvl_fall_e1", 32'(interrupts[5]), 32'd1);
        tick(); check("lvl_fall_e2", 32'(interrupts[5]), 32'd1);
        tick(); check("lvl_fall_e3", 32'(interrupts[5]), 32'd0);

        // 3. Edge line 7 pulse, latch, W1C
        bus_write(A_EDGE, 32'h80);
        bus_write(A_MASK, 32'h80);
        irq_in[7] = 1'b1;
        tick();
        irq_in[7] = 1'b0;
        tick(); tick();
        const_read("edge_pend", A_PEND, 32'h80);
        check("edge_irq", 32'(interrupts[7]), 32'd1);
        repeat (3) tick();
        const_read("edge_hold", A_PEND, 32'h80);
        bus_write(A_PEND, 32'h80);
        const_read("w1c_pend", A_PEND, 32'h0);
        check("w1c_irq", 32'(interrupts[7]), 32'd0);

        // 4. W1C coincident with a new rise: set wins
        irq_in[7] = 1'b1;
        tick(); tick();
        bus_write(A_PEND, 32'h80);
        const_read("set_beats_clr", A_PEND, 32'h80);
        irq_in[7] = 1'b0;
        repeat (2) tick();
        bus_write(A_PEND, 32'h80);
        const_read("clr_after", A_PEND, 32'h0);

        // 5. Software trigger and masking
        bus_write(A_EDGE, 32'h10);
        bus_write(A_MASK, 32'h10);
        bus_write(A_SWTRIG, 32'h10);
        check("swtrig_irq", 32'(interrupts[4]), 32'd1);
        const_read("swtrig_rd0", A_SWTRIG, 32'h0);
        bus_write(A_MASK, 32'h0);
        check("masked_irq", 32'(interrupts[4]), 32'd0);
        const_read("masked_pend", A_PEND, 32'h10);

        // 6. NMI can't be masked; reset drops everything at once
        const_read("nmi_mask", A_MASK, 32'h3);
        irq_in[0] = 1'b1;
        tick(); check("nmi_e1", 32'(interrupts[0]), 32'd0);
        tick(); check("nmi_e2", 32'(interrupts[0]), 32'd0);
        tick(); check("nmi_e3", 32'(interrupts[0]), 32'd1);
        rst_n = 1'b0;
        m_reset();
        #1;
        check("async_rst", 32'(interrupts), 32'h0);
        const_read("async_rst_pend", A_PEND, 32'h0);
        tick();
        rst_n = 1'b1;
        irq_in = '0;
        repeat (3) tick();

        // Random traffic against the model
        for (int it = 0; it < 600; it++) begin
            irq_in = irq_in ^ NL'($urandom & $urandom & $urandom);
            case ($urandom_range(0, 3))
                0: tick();
                1: bus_write(3'($urandom_range(0, 7)), $urandom);
                2: bus_write(3'($urandom_range(0, 2)), $urandom & $urandom);
                default: begin
                    bus_read_check("rnd_read", 3'($urandom_range(0, 7)));
                    tick();
                end
            endcase
        end
        for (int a = 0; a < 8; a++) bus_read_check("final_read", 3'(a));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
